osd_spi_master: RTL and testbench
=================================

Name: osd_spi_master

Overview:
- SPI initiator that drives the OSD overlay's three-wire command port (SPI_SCK, SPI_SS3, SPI_DI at the OSD side) from an on-chip menu/controller core.
- Replaces the external firmware MCU on boards without one.
- Accepts high-level commands (OSD enable/disable, write N bytes starting at line L) over valid/ready, streams data bytes in over a second valid/ready port, and serialises the OSD command protocol.

Parameters:
- CLK_DIV, 2, clk_sys cycles per SCK half-period; legal range 1..255; SCK = clk_sys/(2*CLK_DIV).
- GAP_HALVES, 2, minimum SS3-high time between transactions, in SCK half-periods; legal range 1..15.

Ports:
- clk_sys  in  1  system clock
- reset  in  1  synchronous, active-high reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  master idle, command accepted when valid&ready
- cmd_type  in  1  0 = enable command, 1 = buffer write command
- cmd_arg  in  4  enable: bit0 = enable value; write: start line 0..15
- cmd_len  in  12  write only: byte count minus 1 (0 = 1 byte, 4095 = 4096 bytes)
- data_in  in  8  write payload byte
- data_valid  in  1  payload byte available
- data_ready  out  1  master requests payload byte
- busy  out  1  transaction in progress (not IDLE)
- SPI_SCK  out  1  serial clock; idles low
- SPI_SS3  out  1  OSD select, active low
- SPI_DO  out  1  serial data, MSB first

Behaviour:
- Clock and reset: one clock, clk_sys. Reset is synchronous and active-high.
- Reset values: SPI_SS3=1, SPI_SCK=0, SPI_DO=0, cmd_ready=0, data_ready=0, busy=0. cmd_ready rises the cycle after reset deasserts.
- Reset mid-transfer: SS3 goes high on the next edge. The OSD discards the partial byte; completed bytes remain written.
- Command byte:
  - enable = {4'b0100, 3'b000, cmd_arg[0]}
  - write = {4'b0010, cmd_arg[3:0]}; the OSD places the first byte at address line*256.
- Command accept: on cmd_valid&cmd_ready, latch type/arg/len and load the shift register with the command byte. cmd_ready drops the same edge.
- Bit timing:
  - DO changes only while SCK is low. The OSD samples on SCK rising.
  - Each bit is CLK_DIV cycles low with DO = shreg[7], then CLK_DIV cycles high.
  - At the end of the high phase, shift left and increment the bit counter (3-bit, wraps 7->0).
- States:
  - IDLE: SS3=1, cmd_ready=1.
  - SETUP: SS3=0, SCK low for CLK_DIV cycles.
  - SHIFT: 8 bits as above.
  - BYTE_END: after bit 7, SCK returns low. If type=write and remaining >0 (remaining initialised to len+1), go to FETCH; otherwise go to HOLD.
  - FETCH: data_ready=1, SCK held low, SS3 held low indefinitely. On data_valid, load shreg, decrement remaining, go to SHIFT (the next low phase begins the following cycle).
  - HOLD: SCK low for CLK_DIV cycles.
  - GAP: SS3=1 for GAP_HALVES*CLK_DIV cycles, then IDLE.
- No SCK edges occur outside SHIFT. A stall in FETCH inserts no extra edges.
- Data handshake: data_ready is asserted only in FETCH. At most one byte is consumed per FETCH visit.
- Enable command latency, accept to cmd_ready: CLK_DIV + 16*CLK_DIV + CLK_DIV + GAP_HALVES*CLK_DIV cycles. This is 40 cycles at the defaults.
- A write with len=4095 sends 4097 bytes total. Wrap of the OSD address beyond the buffer is the OSD's concern; the master does not clip.
- cmd_valid while busy is ignored (not latched).

Optional Feature:
- Macro: OSD_SPI_FILL_EN.
- When defined, add ports fill_en (in, 1) and fill_byte (in, 8), both latched at command accept. If a write is accepted with fill_en=1, FETCH completes in one cycle using fill_byte and data_ready stays 0. This is used to clear OSD lines.
- When undefined, these ports are absent and payload always comes from data_in.

Test Plan:
- Enable: CLK_DIV=2, cmd_type=0, arg=1 -> SS3 low, 8 SCK rises sampling 0x41 MSB first, SS3 high. cmd_ready returns exactly 40 cycles after accept.
- Write: line 3, len=1, bytes 0xA5, 0x5A -> 24 SCK rises carrying 0x23, 0xA5, 0x5A. data_ready handshakes exactly twice.
- Stall: hold data_valid low 10 cycles in FETCH -> SCK stays low, SS3 stays low, DO stable. Bit stream is identical to the no-stall case.
- Reset: assert reset after 4 bits of byte 2 -> SS3=1, SCK=0 next cycle. Loopback OSD holds byte 1 only and cmd_ready returns.
- Loopback into the OSD block: write 256 bytes (pattern i^0x3C) to line 0, then enable=1 -> OSD buffer[0..255] matches and the OSD enable flag is set. Follow with enable=0 -> flag cleared.
- With OSD_SPI_FILL_EN: fill_en=1, fill_byte=0x00, line 7, len=255 -> 257 bytes sent, bytes 2..257 are 0x00, data_ready never asserted.

Source files
------------

// File: rtl/osd_spi_master.sv
// osd_spi_master: SPI initiator for the OSD overlay's three-wire command port.
// Takes enable / buffer-write commands over valid/ready, pulls payload bytes
// over a second valid/ready port and serialises them MSB first on SCK/SS3/DO.
// Build option OSD_SPI_FILL_EN adds fill_en/fill_byte so a buffer write can be
// padded with a constant byte (line clear) without touching data_in.
module osd_spi_master #(
    parameter int unsigned CLK_DIV    = 2,
    parameter int unsigned GAP_HALVES = 2
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_type,
    input  logic [3:0]  cmd_arg,
    input  logic [11:0] cmd_len,
    input  logic [7:0]  data_in,
    input  logic        data_valid,
    output logic        data_ready,
`ifdef OSD_SPI_FILL_EN
    input  logic        fill_en,
    input  logic [7:0]  fill_byte,
`endif
    output logic        busy,
    output logic        SPI_SCK,
    output logic        SPI_SS3,
    output logic        SPI_DO
);

    // The byte-end decision (more payload or not) is taken on the same edge
    // that closes the last high phase, so it costs no cycle of its own.
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SETUP = 3'd1;
    localparam logic [2:0] S_SHIFT = 3'd2;
    localparam logic [2:0] S_FETCH = 3'd3;
    localparam logic [2:0] S_HOLD  = 3'd4;
    localparam logic [2:0] S_GAP   = 3'd5;

    localparam logic [11:0] HALF_LAST = 12'(CLK_DIV - 1);
    localparam logic [11:0] GAP_LAST  = 12'(GAP_HALVES * CLK_DIV - 1);

    logic [2:0]  state;
    logic [11:0] cnt;
    logic [2:0]  bit_cnt;
    logic [7:0]  shreg;
    logic        type_q;
    logic [12:0] remaining;
`ifdef OSD_SPI_FILL_EN
    logic        fill_q;
    logic [7:0]  fill_byte_q;
`endif

    logic        accept;
    logic        half_done;
    logic        bit_end;
    logic        fetch_take;
    logic [7:0]  next_byte;

    function automatic logic [7:0] cmd_byte(input logic typ, input logic [3:0] arg);
        return typ ? {4'b0010, arg} : {4'b0100, 3'b000, arg[0]};
    endfunction

    // Handshake strobes and status outputs decoded from the current state.
    always_comb begin
        accept     = cmd_valid && cmd_ready;
        half_done  = (cnt == HALF_LAST);
        bit_end    = (state == S_SHIFT) && SPI_SCK && half_done;
        busy       = (state != S_IDLE);
`ifdef OSD_SPI_FILL_EN
        next_byte  = fill_q ? fill_byte_q : data_in;
        fetch_take = (state == S_FETCH) && (fill_q || data_valid);
        data_ready = (state == S_FETCH) && !fill_q;
`else
        next_byte  = data_in;
        fetch_take = (state == S_FETCH) && data_valid;
        data_ready = (state == S_FETCH);
`endif
    end

    // Sequencer: state, timing counter and the registered SPI pins.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state     <= S_IDLE;
            cnt       <= '0;
            bit_cnt   <= '0;
            cmd_ready <= 1'b0;
            SPI_SS3   <= 1'b1;
            SPI_SCK   <= 1'b0;
            SPI_DO    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        cmd_ready <= 1'b0;
                        state     <= S_SETUP;
                        cnt       <= '0;
                        bit_cnt   <= '0;
                        SPI_SS3   <= 1'b0;
                        SPI_DO    <= cmd_byte(cmd_type, cmd_arg)[7];
                    end else begin
                        cmd_ready <= 1'b1;
                    end
                end
                S_SETUP: begin
                    if (half_done) begin
                        state <= S_SHIFT;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 12'd1;
                    end
                end
                S_SHIFT: begin
                    if (half_done) begin
                        cnt <= '0;
                        if (!SPI_SCK) begin
                            SPI_SCK <= 1'b1;
                        end else begin
                            SPI_SCK <= 1'b0;
                            SPI_DO  <= shreg[6];
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                state <= (type_q && remaining != 13'd0) ? S_FETCH : S_HOLD;
                            end
                        end
                    end else begin
                        cnt <= cnt + 12'd1;
                    end
                end
                S_FETCH: begin
                    // SCK and SS3 simply hold here, so a stalled source adds no edges.
                    if (fetch_take) begin
                        state  <= S_SHIFT;
                        cnt    <= '0;
                        SPI_DO <= next_byte[7];
                    end
                end
                S_HOLD: begin
                    if (half_done) begin
                        state   <= S_GAP;
                        cnt     <= '0;
                        SPI_SS3 <= 1'b1;
                    end else begin
                        cnt <= cnt + 12'd1;
                    end
                end
                S_GAP: begin
                    if (cnt == GAP_LAST) begin
                        state     <= S_IDLE;
                        cnt       <= '0;
                        cmd_ready <= 1'b1;
                    end else begin
                        cnt <= cnt + 12'd1;
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    SPI_SS3 <= 1'b1;
                    SPI_SCK <= 1'b0;
                end
            endcase
        end
    end

    // Datapath: command latch, byte counter and shift register (no reset needed).
    always_ff @(posedge clk_sys) begin
        if (accept) begin
            type_q      <= cmd_type;
            remaining   <= {1'b0, cmd_len} + 13'd1;
            shreg       <= cmd_byte(cmd_type, cmd_arg);
`ifdef OSD_SPI_FILL_EN
            fill_q      <= fill_en;
            fill_byte_q <= fill_byte;
`endif
        end else if (bit_end) begin
            shreg <= {shreg[6:0], 1'b0};
        end else if (fetch_take) begin
            shreg     <= next_byte;
            remaining <= remaining - 13'd1;
        end
    end

endmodule

// File: tb/tb_osd_spi_master.sv
// tb_osd_spi_master: directed bench for osd_spi_master with a loopback OSD
// decoder (command byte, line buffer, enable flag) sampling DO on SCK rises.
module tb_osd_spi_master;

    logic        clk_sys = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_type = 1'b0;
    logic [3:0]  cmd_arg = 4'h0;
    logic [11:0] cmd_len = 12'h000;
    logic [7:0]  data_in = 8'h00;
    logic        data_valid = 1'b0;
    logic        data_ready;
    logic        busy;
    logic        SPI_SCK;
    logic        SPI_SS3;
    logic        SPI_DO;
`ifdef OSD_SPI_FILL_EN
    logic        fill_en = 1'b0;
    logic [7:0]  fill_byte = 8'h00;
`endif

    always #5 clk_sys = ~clk_sys;

    osd_spi_master #(.CLK_DIV(2), .GAP_HALVES(2)) dut (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_type  (cmd_type),
        .cmd_arg   (cmd_arg),
        .cmd_len   (cmd_len),
        .data_in   (data_in),
        .data_valid(data_valid),
        .data_ready(data_ready),
`ifdef OSD_SPI_FILL_EN
        .fill_en   (fill_en),
        .fill_byte (fill_byte),
`endif
        .busy      (busy),
        .SPI_SCK   (SPI_SCK),
        .SPI_SS3   (SPI_SS3),
        .SPI_DO    (SPI_DO)
    );

    int total = 0;
    int bad = 0;

    // loopback OSD state
    logic [7:0]  osd_mem [0:4095];
    logic        osd_en = 1'b0;
    logic [11:0] wr_addr = 12'h000;
    logic [7:0]  rx_sr = 8'h00;
    logic [7:0]  rx_cmd = 8'h00;
    logic [7:0]  rx_q [$];
    int          rx_bits = 0;
    int          sck_rises = 0;
    int          sck_oof = 0;
    int          do_viol = 0;
    int          dr_seen = 0;
    int          hs_cnt = 0;
    int          busy_bad = 0;
    int          stall_bad = 0;
    logic        prev_ss3 = 1'b1;
    logic        prev_sck = 1'b0;
    logic        prev_do = 1'b0;

    typedef struct {
        logic        typ;
        logic [3:0]  arg;
        logic [11:0] len;
        logic [7:0]  seed;
        logic        alt;
        logic        poke;
        logic [7:0]  exp_cmd;
        int          exp_bytes;
        int          exp_lat;
        logic        exp_en;
    } vec_t;

    vec_t vecs [0:6];

    function automatic logic [7:0] pat(input logic [7:0] seed, input logic alt, input int i);
        if (alt) return i[0] ? ~seed : seed;
        return seed ^ 8'(i);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // OSD decoder: samples DO on each SCK rise while SS3 is low; a partial byte
    // is dropped when SS3 rises.
    always @(negedge clk_sys) begin
        if (!SPI_SS3 && prev_ss3) rx_q.delete();
        if (SPI_SS3) rx_bits = 0;
        if (SPI_SCK && !prev_sck) begin
            sck_rises++;
            if (SPI_SS3) begin
                sck_oof++;
            end else begin
                rx_sr = {rx_sr[6:0], SPI_DO};
                rx_bits++;
                if (rx_bits == 8) begin
                    rx_bits = 0;
                    if (rx_q.size() == 0) begin
                        rx_cmd = rx_sr;
                        if (rx_sr[7:4] == 4'h4) osd_en = rx_sr[0];
                        wr_addr = {rx_sr[3:0], 8'h00};
                    end else if (rx_cmd[7:4] == 4'h2) begin
                        osd_mem[wr_addr] = rx_sr;
                        wr_addr = wr_addr + 12'd1;
                    end
                    rx_q.push_back(rx_sr);
                end
            end
        end
        if (SPI_DO != prev_do && prev_sck && SPI_SCK) do_viol++;
        if (data_ready) dr_seen++;
        prev_ss3 = SPI_SS3;
        prev_sck = SPI_SCK;
        prev_do  = SPI_DO;
    end

    // payload handshake counter
    always @(posedge clk_sys) begin
        if (data_valid && data_ready) hs_cnt++;
    end

    // Issue one command, feed payload, return accept-to-cmd_ready latency.
    // lat = -1 on timeout, -2 when stopped early for abort_bytes.
    task automatic run_cmd(input logic typ, input logic [3:0] arg, input logic [11:0] len,
                           input logic [7:0] seed, input logic alt, input logic poke,
                           input int stall, input int abort_bytes, output int lat);
        int hs_base;
        int st;
        int wait_n;
        logic [7:0] do_ref;
        logic done;
        st = stall;
        lat = -1;
        busy_bad = 0;
        stall_bad = 0;
        do_ref = 1'b0;
        done = 1'b0;
        wait_n = 0;
        while (!cmd_ready && wait_n < 200) begin
            @(negedge clk_sys);
            wait_n++;
        end
        if (!cmd_ready) begin
            check("cmd_ready_wait", 32'(cmd_ready), 1);
            return;
        end
        cmd_type  = typ;
        cmd_arg   = arg;
        cmd_len   = len;
        cmd_valid = 1'b1;
        hs_base   = hs_cnt;
        @(posedge clk_sys);
        for (int k = 0; k < 20000 && !done; k++) begin
            @(negedge clk_sys);
            cmd_valid = poke && (k < 20);
            if (poke) begin
                cmd_type = 1'b1;
                cmd_arg  = 4'hF;
            end
            if (cmd_ready) begin
                lat = k;
                done = 1'b1;
            end else if (abort_bytes > 0 && rx_q.size() == abort_bytes && rx_bits == 4) begin
                lat = -2;
                done = 1'b1;
            end else begin
                if (!busy) busy_bad++;
                data_in = pat(seed, alt, hs_cnt - hs_base);
                if (data_ready && st > 0) begin
                    if (st == stall) do_ref = {7'b0, SPI_DO};
                    if (SPI_SCK || SPI_SS3 || SPI_DO != do_ref[0]) stall_bad++;
                    st--;
                    data_valid = 1'b0;
                end else begin
                    data_valid = data_ready;
                end
            end
        end
        cmd_valid  = 1'b0;
        data_valid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    initial begin
        int lat;
        int errs;
        int hs0;
        int sck0;
        int dr0;
        logic [7:0] got_cmd;

        for (int a = 0; a < 4096; a++) osd_mem[a] = 8'h00;

        //           typ  arg    len     seed   alt   poke  cmd    n    lat   en
        vecs[0] = '{1'b0, 4'h1, 12'd0,   8'h00, 1'b0, 1'b0, 8'h41, 1,   40,   1'b1};
        vecs[1] = '{1'b1, 4'h3, 12'd1,   8'hA5, 1'b1, 1'b0, 8'h23, 3,   106,  1'b1};
        vecs[2] = '{1'b0, 4'hE, 12'd0,   8'h00, 1'b0, 1'b0, 8'h40, 1,   40,   1'b0};
        vecs[3] = '{1'b1, 4'h0, 12'd255, 8'h3C, 1'b0, 1'b0, 8'h20, 257, 8488, 1'b0};
        vecs[4] = '{1'b0, 4'h1, 12'd0,   8'h00, 1'b0, 1'b1, 8'h41, 1,   40,   1'b1};
        vecs[5] = '{1'b0, 4'h0, 12'd0,   8'h00, 1'b0, 1'b0, 8'h40, 1,   40,   1'b0};
        vecs[6] = '{1'b1, 4'hF, 12'd0,   8'h77, 1'b0, 1'b0, 8'h2F, 2,   73,   1'b0};

        // reset state
        repeat (3) @(negedge clk_sys);
        check("reset_pins {ss3,sck,do,cmd_rdy,data_rdy,busy}",
              32'({SPI_SS3, SPI_SCK, SPI_DO, cmd_ready, data_ready, busy}), 32'b100000);
        reset = 1'b0;
        check("cmd_ready_at_deassert", 32'(cmd_ready), 0);
        @(negedge clk_sys);
        check("cmd_ready_after_reset", 32'(cmd_ready), 1);

        // table-driven commands
        for (int i = 0; i < 7; i++) begin
            hs0  = hs_cnt;
            sck0 = sck_rises;
            run_cmd(vecs[i].typ, vecs[i].arg, vecs[i].len, vecs[i].seed, vecs[i].alt,
                    vecs[i].poke, 0, 0, lat);
            got_cmd = (rx_q.size() > 0) ? rx_q[0] : 8'h00;
            check($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
            check($sformatf("v%0d_cmd_byte", i), 32'(got_cmd), 32'(vecs[i].exp_cmd));
            check($sformatf("v%0d_byte_count", i), rx_q.size(), vecs[i].exp_bytes);
            check($sformatf("v%0d_sck_rises", i), sck_rises - sck0, 8 * vecs[i].exp_bytes);
            check($sformatf("v%0d_handshakes", i), hs_cnt - hs0, vecs[i].exp_bytes - 1);
            check($sformatf("v%0d_osd_enable", i), 32'(osd_en), 32'(vecs[i].exp_en));
            check($sformatf("v%0d_busy_low", i), busy_bad, 0);
            errs = 0;
            for (int b = 1; b < rx_q.size() && b < vecs[i].exp_bytes; b++)
                if (rx_q[b] !== pat(vecs[i].seed, vecs[i].alt, b - 1)) errs++;
            check($sformatf("v%0d_payload_errs", i), errs, 0);
        end

        // OSD buffer contents written by the table
        errs = 0;
        for (int a = 0; a < 256; a++)
            if (osd_mem[a] !== (8'(a) ^ 8'h3C)) errs++;
        check("osd_line0_errs", errs, 0);
        check("osd_line3", 32'({osd_mem[12'h300], osd_mem[12'h301]}), 32'h0000A55A);
        check("osd_line15", 32'(osd_mem[12'hF00]), 32'h77);

        // stall 10 cycles in the first FETCH
        hs0 = hs_cnt;
        run_cmd(1'b1, 4'h4, 12'd1, 8'hA5, 1'b1, 1'b0, 10, 0, lat);
        check("stall_latency", lat, 116);
        check("stall_byte_count", rx_q.size(), 3);
        check("stall_stream", (rx_q.size() == 3) ? 32'({rx_q[0], rx_q[1], rx_q[2]}) : -1,
              32'h0024A55A);
        check("stall_pins_moved", stall_bad, 0);
        check("stall_handshakes", hs_cnt - hs0, 2);

        // reset after 4 bits of the second payload byte
        run_cmd(1'b1, 4'h9, 12'd2, 8'hC3, 1'b0, 1'b0, 0, 2, lat);
        check("abort_reached", lat, -2);
        reset = 1'b1;
        @(negedge clk_sys);
        check("midrst_pins {ss3,sck,do,cmd_rdy,busy}",
              32'({SPI_SS3, SPI_SCK, SPI_DO, cmd_ready, busy}), 32'b10000);
        @(negedge clk_sys);
        reset = 1'b0;
        @(negedge clk_sys);
        check("midrst_cmd_ready", 32'(cmd_ready), 1);
        check("midrst_bytes_seen", rx_q.size(), 2);
        check("midrst_partial_dropped", rx_bits, 0);
        check("midrst_osd_mem", 32'({osd_mem[12'h900], osd_mem[12'h901]}), 32'h0000C300);

`ifdef OSD_SPI_FILL_EN
        // fill mode: constant payload, no data handshake
        fill_en   = 1'b1;
        fill_byte = 8'h00;
        dr0 = dr_seen;
        run_cmd(1'b1, 4'h7, 12'd255, 8'h55, 1'b0, 1'b0, 0, 0, lat);
        fill_en = 1'b0;
        check("fill_latency", lat, 8488);
        check("fill_byte_count", rx_q.size(), 257);
        check("fill_cmd_byte", (rx_q.size() > 0) ? 32'(rx_q[0]) : -1, 32'h27);
        errs = 0;
        for (int b = 1; b < rx_q.size(); b++)
            if (rx_q[b] !== 8'h00) errs++;
        check("fill_nonzero_bytes", errs, 0);
        check("fill_data_ready_cycles", dr_seen - dr0, 0);
`else
        dr0 = dr_seen;
        check("idle_data_ready_cycles", dr_seen - dr0 + 32'(data_ready), 0);
`endif

        // whole-run protocol checks
        check("sck_rise_outside_frame", sck_oof, 0);
        check("do_change_while_sck_high", do_viol, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
